// File: rtl/clk_gen_pkg.sv
// ============================================================================
// Module   : clk_gen_pkg
// Purpose  : Shared state encoding and default sizing for the clock generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } clk_gen_state_t;

    localparam int DEFAULT_W    = 16;
    localparam int DEFAULT_HALF = 10;

endpackage

`default_nettype wire

// File: rtl/clk_cfg_shadow.sv
// ============================================================================
// Module   : clk_cfg_shadow
// Purpose  : Config handshake, zero rejection and single-entry pending slot.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_cfg_shadow #(
    parameter int W = clk_gen_pkg::DEFAULT_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_half,
    input  logic         idle,
    input  logic         apply,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         pending_valid,
    output logic [W-1:0] pending_half,
    output logic         direct_wr
);

    logic         r_pend_valid;
    logic [W-1:0] r_pend_half;
    logic         r_err;
    logic         w_xfer;
    logic         w_zero;

    assign w_xfer = cfg_valid && !r_pend_valid;
    assign w_zero = (cfg_half == '0);

    // An idle generator has no period in flight, so the value bypasses the slot.
    assign direct_wr = w_xfer && !w_zero && idle;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend_valid <= 1'b0;
            r_pend_half  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= w_xfer && w_zero;
            if (apply) begin
                r_pend_valid <= 1'b0;
            end else if (w_xfer && !w_zero && !idle) begin
                r_pend_valid <= 1'b1;
                r_pend_half  <= cfg_half;
            end
        end
    end

    assign cfg_ready     = !r_pend_valid;
    assign cfg_err       = r_err;
    assign pending_valid = r_pend_valid;
    assign pending_half  = r_pend_half;

endmodule

`default_nettype wire

// File: rtl/clk_div_gen.sv
// ============================================================================
// Module   : clk_div_gen
// Purpose  : Glitch-free programmable 50% duty clock divider with edge count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_gen #(
    parameter int W            = clk_gen_pkg::DEFAULT_W,
    parameter int DEFAULT_HALF = clk_gen_pkg::DEFAULT_HALF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [W-1:0]     cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic [W-1:0]     active_half,
    output logic [CNT_W-1:0] edge_cnt
);

    import clk_gen_pkg::*;

    localparam logic [1:0]       c_IDLE    = IDLE;
    localparam logic [1:0]       c_HIGH    = HIGH;
    localparam logic [1:0]       c_LOW     = LOW;
    localparam logic [W-1:0]     c_ONE     = W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [W-1:0]     r_cnt;
    logic [W-1:0]     r_active;
    logic             r_clk_out;
    logic             r_rise;
    logic [CNT_W-1:0] r_edge_cnt;

    logic             w_idle;
    logic             w_cnt_zero;
    logic             w_apply;
    logic             w_direct_wr;
    logic             w_pend_valid;
    logic [W-1:0]     w_pend_half;
    logic [W-1:0]     w_start_half;
    logic [W-1:0]     w_next_half;

    assign w_idle     = (r_state == c_IDLE);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_apply    = (r_state == c_LOW) && w_cnt_zero && w_pend_valid;

    // A value accepted on the starting edge already governs the first HIGH phase.
    assign w_start_half = w_direct_wr ? cfg_half : r_active;
    assign w_next_half  = w_pend_valid ? w_pend_half : r_active;

    clk_cfg_shadow #(
        .W (W)
    ) u_cfg_shadow (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_valid     (cfg_valid),
        .cfg_half      (cfg_half),
        .idle          (w_idle),
        .apply         (w_apply),
        .cfg_ready     (cfg_ready),
        .cfg_err       (cfg_err),
        .pending_valid (w_pend_valid),
        .pending_half  (w_pend_half),
        .direct_wr     (w_direct_wr)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_active   <= W'(DEFAULT_HALF);
            r_clk_out  <= 1'b0;
            r_rise     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_rise <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_clk_out <= 1'b0;
                    if (w_direct_wr) begin
                        r_active <= cfg_half;
                    end
                    if (en) begin
                        r_state    <= c_HIGH;
                        r_clk_out  <= 1'b1;
                        r_rise     <= 1'b1;
                        r_cnt      <= w_start_half - c_ONE;
                        r_edge_cnt <= r_edge_cnt + c_CNT_ONE;
                    end
                end
                c_HIGH: begin
                    if (w_cnt_zero) begin
                        r_state   <= c_LOW;
                        r_clk_out <= 1'b0;
                        r_cnt     <= r_active - c_ONE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                c_LOW: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else begin
                        // Period boundary: the only point a pending half may take effect.
                        r_active <= w_next_half;
                        if (en) begin
                            r_state    <= c_HIGH;
                            r_clk_out  <= 1'b1;
                            r_rise     <= 1'b1;
                            r_cnt      <= w_next_half - c_ONE;
                            r_edge_cnt <= r_edge_cnt + c_CNT_ONE;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_clk_out <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out     = r_clk_out;
    assign rise_pulse  = r_rise;
    assign active_half = r_active;
    assign edge_cnt    = r_edge_cnt;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_gen.sv
// ============================================================================
// Module   : tb_clk_div_gen
// Purpose  : Self-checking bench for clk_div_gen against a phase-length model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_out;
    logic        rise_pulse;
    logic [15:0] active_half;
    logic [31:0] edge_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: remaining length of the visible phase, and a config FIFO of depth 1.
    bit          m_run, m_out, m_rise, m_err;
    int unsigned m_left, m_active;
    logic [31:0] m_edges;
    int unsigned m_pend[$];

    clk_div_gen #(
        .W            (16),
        .DEFAULT_HALF (10),
        .CNT_W        (32)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .clk_out     (clk_out),
        .rise_pulse  (rise_pulse),
        .active_half (active_half),
        .edge_cnt    (edge_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_start();
        m_run  = 1'b1;
        m_out  = 1'b1;
        m_left = m_active;
        m_rise = 1'b1;
        m_edges = m_edges + 32'd1;
    endtask

    task automatic model_step();
        bit xfer;
        if (!rstn) begin
            m_run = 0; m_out = 0; m_rise = 0; m_err = 0;
            m_left = 0; m_active = 10; m_edges = '0;
            m_pend.delete();
        end else begin
            xfer   = cfg_valid && (m_pend.size() == 0);
            m_err  = xfer && (cfg_half == 0);
            m_rise = 0;
            if (!m_run) begin
                if (xfer && cfg_half != 0) m_active = cfg_half;
                if (en) model_start();
                else m_out = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_out) begin
                        m_out  = 0;
                        m_left = m_active;
                    end else begin
                        if (m_pend.size() != 0) m_active = m_pend.pop_front();
                        if (en) model_start();
                        else begin
                            m_run = 0;
                            m_out = 0;
                        end
                    end
                end
                if (xfer && cfg_half != 0) m_pend.push_back(int'(cfg_half));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("clk_out",     64'(clk_out),     64'(m_out));
        chk("rise_pulse",  64'(rise_pulse),  64'(m_rise));
        chk("cfg_ready",   64'(cfg_ready),   64'(m_pend.size() == 0));
        chk("cfg_err",     64'(cfg_err),     64'(m_err));
        chk("active_half", 64'(active_half), 64'(m_active));
        chk("edge_cnt",    64'(edge_cnt),    64'(m_edges));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; cfg_valid = 1'b1; cfg_half = 16'd5;
        ticks(3);
        chk("reset_active", 64'(active_half), 64'd10);
        chk("reset_ready",  64'(cfg_ready),   64'd1);
        cfg_valid = 1'b0;
        rstn = 1'b1;
        tick();

        // Default H=10 for five periods.
        en = 1'b1;
        ticks(90);
        chk("edge_cnt_5", 64'(edge_cnt), 64'd5);

        // Mid-HIGH reprogram to 20 takes effect after the current period.
        for (int k = 0; k < 40; k++) begin
            if (rise_pulse === 1'b1) break;
            tick();
        end
        chk("rise_seen", 64'(rise_pulse), 64'd1);
        ticks(2);
        cfg_valid = 1'b1; cfg_half = 16'd20;
        tick();
        cfg_valid = 1'b0;
        chk("ready_low_after_accept", 64'(cfg_ready), 64'd0);
        ticks(120);

        // Zero half period is rejected.
        cfg_valid = 1'b1; cfg_half = 16'd0;
        tick();
        cfg_valid = 1'b0;
        chk("zero_err_pulse", 64'(cfg_err), 64'd1);
        tick();
        chk("zero_err_clear", 64'(cfg_err), 64'd0);
        ticks(30);

        // Drain to IDLE, then H=1 toggling.
        en = 1'b0;
        ticks(90);
        cfg_valid = 1'b1; cfg_half = 16'd1;
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        ticks(12);

        // H=10, drop en early in HIGH; then restart from IDLE.
        en = 1'b0;
        ticks(4);
        cfg_valid = 1'b1; cfg_half = 16'd10;
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        ticks(4);
        en = 1'b0;
        ticks(25);
        chk("idle_clk_out", 64'(clk_out), 64'd0);
        en = 1'b1;
        tick();
        chk("restart_high", 64'(clk_out), 64'd1);

        // Sweep through the handshake.
        for (int h = 10; h <= 40; h += 10) begin
            for (int k = 0; k < 200; k++) begin
                if (cfg_ready === 1'b1) break;
                tick();
            end
            cfg_valid = 1'b1; cfg_half = 16'(h);
            tick();
            cfg_valid = 1'b0;
            ticks(2 * h + 60);
        end

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_half  = 16'($urandom_range(0, 5));
            rstn      = ($urandom_range(0, 399) != 0);
            tick();
        end
        rstn = 1'b1; cfg_valid = 1'b0; en = 1'b0;

        // Reset during LOW with an update pending.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        cfg_valid = 1'b1; cfg_half = 16'd4; en = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (clk_out === 1'b0) break;
            tick();
        end
        chk("reach_low", 64'(clk_out), 64'd0);
        cfg_valid = 1'b1; cfg_half = 16'd7;
        tick();
        cfg_valid = 1'b0;
        chk("pending_held", 64'(cfg_ready), 64'd0);
        tick();
        rstn = 1'b0;
        tick();
        chk("rst_active", 64'(active_half), 64'd10);
        chk("rst_ready",  64'(cfg_ready),   64'd1);
        chk("rst_clk",    64'(clk_out),     64'd0);
        chk("rst_edges",  64'(edge_cnt),    64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
